present_key_schedule: RTL and testbench

Sequential, parametrised PRESENT key schedule that generates all 32 round keys for 80- or 128-bit master keys. Holds the key register, applies one update per accepted round key, and streams round keys to the datapath via a valid/ready handshake. Optionally it runs the schedule backwards for decryption. It sits between the key input and the PRESENT round datapath, replacing per-round combinational key update instances.

---
 rtl/present_pkg.sv | 38 +++
 rtl/present_key_step.sv | 59 +++++
 rtl/present_key_schedule.sv | 97 +++++++++
 tb/tb_present_key_schedule.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared PRESENT definitions: S-box tables, legal key widths, round-key count
// and counter width, and the key-schedule FSM state type.
package present_pkg;

    localparam int KEY_W80        = 80;
    localparam int KEY_W128       = 128;
    localparam int NUM_ROUND_KEYS = 32;
    localparam int ROUND_CNT_W    = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } schedState_t;

    function automatic logic [3:0] sBox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sBoxInv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/present_key_step.sv
// Combinational single-round PRESENT key-register update (80 or 128 bit).
// The inverse direction exists only when PRESENT_KEY_INVERSE_EN is defined.
module present_key_step
    import present_pkg::*;
#(
    parameter int KEY_WIDTH = 80
) (
    input  logic [KEY_WIDTH-1:0] key,
    input  logic [4:0]           roundCnt,
`ifdef PRESENT_KEY_INVERSE_EN
    input  logic                 inverse,
`endif
    output logic [KEY_WIDTH-1:0] nextKey
);

    generate
        if (KEY_WIDTH == KEY_W80) begin : gK80
            logic [79:0] fwd;
            always_comb begin
                fwd          = {key[18:0], key[79:19]};
                fwd[79:76]   = sBox(fwd[79:76]);
                fwd[19:15]   = fwd[19:15] ^ roundCnt;
            end
`ifdef PRESENT_KEY_INVERSE_EN
            // Undo in reverse order: counter XOR, S-box, then rotate right 61.
            logic [79:0] inv;
            always_comb begin
                inv          = key;
                inv[19:15]   = inv[19:15] ^ roundCnt;
                inv[79:76]   = sBoxInv(inv[79:76]);
            end
            assign nextKey = inverse ? {inv[60:0], inv[79:61]} : fwd;
`else
            assign nextKey = fwd;
`endif
        end else begin : gK128
            logic [127:0] fwd;
            always_comb begin
                fwd          = {key[66:0], key[127:67]};
                fwd[127:124] = sBox(fwd[127:124]);
                fwd[123:120] = sBox(fwd[123:120]);
                fwd[66:62]   = fwd[66:62] ^ roundCnt;
            end
`ifdef PRESENT_KEY_INVERSE_EN
            logic [127:0] inv;
            always_comb begin
                inv          = key;
                inv[66:62]   = inv[66:62] ^ roundCnt;
                inv[127:124] = sBoxInv(inv[127:124]);
                inv[123:120] = sBoxInv(inv[123:120]);
            end
            assign nextKey = inverse ? {inv[60:0], inv[127:61]} : fwd;
`else
            assign nextKey = fwd;
`endif
        end
    endgenerate

endmodule

// File: rtl/present_key_schedule.sv
// Sequential PRESENT key schedule streaming 32 round keys over valid/ready.
// Define PRESENT_KEY_INVERSE_EN to add the backwards (decryption) schedule.
module present_key_schedule
    import present_pkg::*;
#(
    parameter int KEY_WIDTH = 80
) (
    input  logic                 Clk_ik,
    input  logic                 Reset_iran,
    input  logic [KEY_WIDTH-1:0] Key_ib,
    input  logic                 Load_i,
    input  logic                 Inverse_i,
    output logic [63:0]          RoundKey_ob,
    output logic [5:0]           RoundIdx_ob,
    output logic                 RoundKeyValid_o,
    input  logic                 RoundKeyReady_i,
    output logic                 Busy_o,
    output logic                 Done_o
);

    generate
        if (KEY_WIDTH != KEY_W80 && KEY_WIDTH != KEY_W128) begin : gBadWidth
            $error("present_key_schedule: KEY_WIDTH must be 80 or 128");
        end
    endgenerate

    localparam logic [ROUND_CNT_W-1:0] FIRST_IDX = ROUND_CNT_W'(1);
    localparam logic [ROUND_CNT_W-1:0] LAST_IDX  = ROUND_CNT_W'(NUM_ROUND_KEYS);

    schedState_t            state, stateNext;
    logic [KEY_WIDTH-1:0]   keyReg, stepKey;
    logic [ROUND_CNT_W-1:0] cnt;
    logic [4:0]             stepCnt;
    logic                   invMode, loadInv, accept, lastKey;

`ifdef PRESENT_KEY_INVERSE_EN
    assign loadInv = Inverse_i;
    always_ff @(posedge Clk_ik or negedge Reset_iran) begin
        if (!Reset_iran)                   invMode <= 1'b0;
        else if (state == IDLE && Load_i)  invMode <= Inverse_i;
    end
`else
    logic unusedInv;
    assign unusedInv = Inverse_i;
    assign loadInv   = 1'b0;
    assign invMode   = 1'b0;
`endif

    assign accept  = (state == RUN) && RoundKeyReady_i;
    assign lastKey = invMode ? (cnt == FIRST_IDX) : (cnt == LAST_IDX);
    // Inverse step for index c undoes the forward step taken at c-1.
    assign stepCnt = invMode ? 5'(cnt - FIRST_IDX) : cnt[4:0];

    present_key_step #(.KEY_WIDTH(KEY_WIDTH)) uStep (
        .key      (keyReg),
        .roundCnt (stepCnt),
`ifdef PRESENT_KEY_INVERSE_EN
        .inverse  (invMode),
`endif
        .nextKey  (stepKey)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (Load_i) stateNext = RUN;
            RUN:     if (accept && lastKey) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk_ik or negedge Reset_iran) begin
        if (!Reset_iran) state <= IDLE;
        else             state <= stateNext;
    end

    always_ff @(posedge Clk_ik or negedge Reset_iran) begin
        if (!Reset_iran) begin
            keyReg <= '0;
            cnt    <= '0;
        end else if (state == IDLE && Load_i) begin
            keyReg <= Key_ib;
            cnt    <= loadInv ? LAST_IDX : FIRST_IDX;
        end else if (accept && !lastKey) begin
            keyReg <= stepKey;
            cnt    <= invMode ? cnt - FIRST_IDX : cnt + FIRST_IDX;
        end
    end

    assign RoundKey_ob     = keyReg[KEY_WIDTH-1 -: 64];
    assign RoundIdx_ob     = cnt;
    assign RoundKeyValid_o = (state == RUN);
    assign Busy_o          = (state != IDLE);
    assign Done_o          = (state == DONE);

endmodule

// File: tb/tb_present_key_schedule.sv
// Directed bench for present_key_schedule: 80- and 128-bit instances, checked
// against hand-computed keys and an independent bit-level schedule model.
module tb_present_key_schedule;

    logic         clk, rst_n;
    logic [79:0]  keyInA;
    logic         loadA, invA, rdyA, validA, busyA, doneA;
    logic [63:0]  rkA;
    logic [5:0]   idxA;
    logic [127:0] keyInB;
    logic         loadB, invB, rdyB, validB, busyB, doneB;
    logic [63:0]  rkB;
    logic [5:0]   idxB;

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    logic [63:0] exp80  [1:32];
    logic [63:0] exp128 [1:32];
    logic [79:0] fin80;
    logic [63:0] capKey [32];
    logic [5:0]  capIdx [32];
    int          capN, holdErr, cyc;

    present_key_schedule #(.KEY_WIDTH(80)) dutA (
        .Clk_ik(clk), .Reset_iran(rst_n), .Key_ib(keyInA), .Load_i(loadA),
        .Inverse_i(invA), .RoundKey_ob(rkA), .RoundIdx_ob(idxA),
        .RoundKeyValid_o(validA), .RoundKeyReady_i(rdyA), .Busy_o(busyA), .Done_o(doneA)
    );

    present_key_schedule #(.KEY_WIDTH(128)) dutB (
        .Clk_ik(clk), .Reset_iran(rst_n), .Key_ib(keyInB), .Load_i(loadB),
        .Inverse_i(invB), .RoundKey_ob(rkB), .RoundIdx_ob(idxB),
        .RoundKeyValid_o(validB), .RoundKeyReady_i(rdyB), .Busy_o(busyB), .Done_o(doneB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bitwise model: new[i] = old[i+19 mod 80] is a left rotation by 61.
    task automatic model80(input logic [79:0] mk);
        logic [79:0] k, n;
        k = mk;
        for (int r = 1; r <= 32; r++) begin
            exp80[r] = k[79:16];
            if (r < 32) begin
                for (int i = 0; i < 80; i++) n[i] = k[(i + 19) % 80];
                n[79:76] = SB[n[79:76]];
                for (int b = 0; b < 5; b++) n[15 + b] = n[15 + b] ^ r[b];
                k = n;
            end
        end
        fin80 = k;
    endtask

    task automatic model128(input logic [127:0] mk);
        logic [127:0] k, n;
        k = mk;
        for (int r = 1; r <= 32; r++) begin
            exp128[r] = k[127:64];
            if (r < 32) begin
                for (int i = 0; i < 128; i++) n[i] = k[(i + 67) % 128];
                n[127:124] = SB[n[127:124]];
                n[123:120] = SB[n[123:120]];
                for (int b = 0; b < 5; b++) n[62 + b] = n[62 + b] ^ r[b];
                k = n;
            end
        end
    endtask

    task automatic loadA80(input logic [79:0] k, input logic inv);
        @(posedge clk); #1;
        keyInA = k; invA = inv; loadA = 1'b1;
        @(posedge clk); #1;
        loadA = 1'b0; keyInA = '1; invA = ~inv;
    endtask

    // Streams up to 32 keys from dutA, recording accepted keys and hold violations.
    task automatic collect80(input bit rnd, input int pulseAt);
        logic [63:0] prevKey;
        logic [5:0]  prevIdx;
        bit          prevStall;
        capN = 0; holdErr = 0; cyc = 0; prevStall = 0;
        prevKey = '0; prevIdx = '0;
        while (capN < 32 && cyc < 400) begin
            rdyA  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            loadA = (cyc == pulseAt);
            if (cyc == pulseAt) keyInA = 80'hFFFF_0000_FFFF_0000_FFFF;
            @(negedge clk);
            cyc++;
            if (prevStall && (rkA !== prevKey || idxA !== prevIdx)) holdErr++;
            if (validA && rdyA) begin
                capKey[capN] = rkA; capIdx[capN] = idxA; capN++;
            end
            prevStall = validA && !rdyA;
            prevKey = rkA; prevIdx = idxA;
            @(posedge clk); #1;
        end
        loadA = 1'b0; rdyA = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({rkA, idxA, validA, busyA, doneA} !== '0) begin
            bad++; $display("FAIL reset80: got key=%h idx=%0d v=%b b=%b d=%b, want all 0", rkA, idxA, validA, busyA, doneA);
        end
        total++;
        if ({rkB, idxB, validB, busyB, doneB} !== '0) begin
            bad++; $display("FAIL reset128: got key=%h idx=%0d v=%b b=%b d=%b, want all 0", rkB, idxB, validB, busyB, doneB);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (validA !== 1'b0 || busyA !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset: got v=%b b=%b, want 0 0", validA, busyA);
        end
    endtask

    task automatic check_done_A(input string name);
        @(negedge clk);
        total++;
        if (validA !== 1'b0 || doneA !== 1'b1 || busyA !== 1'b1) begin
            bad++; $display("FAIL %s_done: got v=%b d=%b b=%b, want 0 1 1", name, validA, doneA, busyA);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (busyA !== 1'b0 || doneA !== 1'b0) begin
            bad++; $display("FAIL %s_idle: got b=%b d=%b, want 0 0", name, busyA, doneA);
        end
    endtask

    task automatic check_fwd_A(input string name);
        total++;
        if (capN !== 32) begin
            bad++; $display("FAIL %s_count: got %0d keys, want 32", name, capN);
        end
        for (int j = 0; j < capN; j++) begin
            total++;
            if (capKey[j] !== exp80[j + 1] || capIdx[j] !== 6'(j + 1)) begin
                bad++; $display("FAIL %s_k%0d: got %h idx %0d, want %h idx %0d", name, j + 1, capKey[j], capIdx[j], exp80[j + 1], j + 1);
            end
        end
    endtask

    task automatic test_fwd80;
        model80('0);
        loadA80('0, 1'b0);
        collect80(1'b0, -1);
        total++;
        if (capKey[0] !== 64'h0 || capKey[1] !== 64'hC000_0000_0000_0000 || capKey[2] !== 64'h5000_1800_0000_0001) begin
            bad++; $display("FAIL fwd80_hand: got K1=%h K2=%h K3=%h, want 0 c000000000000000 5000180000000001", capKey[0], capKey[1], capKey[2]);
        end
        total++;
        if (cyc !== 32) begin
            bad++; $display("FAIL fwd80_throughput: got %0d cycles, want 32", cyc);
        end
        check_fwd_A("fwd80");
        check_done_A("fwd80");
    endtask

    task automatic test_fwd128;
        int n, c;
        model128('0);
        @(posedge clk); #1 keyInB = '0; invB = 1'b0; loadB = 1'b1; rdyB = 1'b1;
        @(posedge clk); #1 loadB = 1'b0;
        n = 0; c = 0;
        while (n < 32 && c < 100) begin
            @(negedge clk); c++;
            if (validB) begin
                total++;
                if (rkB !== exp128[n + 1] || idxB !== 6'(n + 1)) begin
                    bad++; $display("FAIL fwd128_k%0d: got %h idx %0d, want %h", n + 1, rkB, idxB, exp128[n + 1]);
                end
                if (n == 1) begin
                    total++;
                    if (rkB !== 64'hCC00_0000_0000_0000) begin
                        bad++; $display("FAIL fwd128_hand_k2: got %h, want cc00000000000000", rkB);
                    end
                end
                n++;
            end
            @(posedge clk); #1;
        end
        total++;
        if (n !== 32 || c !== 32) begin
            bad++; $display("FAIL fwd128_count: got %0d keys in %0d cycles, want 32 in 32", n, c);
        end
        @(negedge clk);
        total++;
        if (doneB !== 1'b1 || validB !== 1'b0) begin
            bad++; $display("FAIL fwd128_done: got d=%b v=%b, want 1 0", doneB, validB);
        end
    endtask

    task automatic test_ready_toggle;
        model80(80'h0123_4567_89AB_CDEF_FEDC);
        loadA80(80'h0123_4567_89AB_CDEF_FEDC, 1'b0);
        collect80(1'b1, -1);
        total++;
        if (holdErr !== 0) begin
            bad++; $display("FAIL toggle_hold: got %0d hold violations, want 0", holdErr);
        end
        check_fwd_A("toggle");
        check_done_A("toggle");
    endtask

    task automatic test_load_during_run;
        model80(80'hA5A5_5A5A_C3C3_3C3C_9696);
        loadA80(80'hA5A5_5A5A_C3C3_3C3C_9696, 1'b0);
        collect80(1'b0, 6);
        check_fwd_A("loadrun");
        check_done_A("loadrun");
    endtask

    task automatic test_reset_mid;
        int c;
        loadA80(80'hA5A5_5A5A_C3C3_3C3C_9696, 1'b0);
        rdyA = 1'b1; c = 0;
        do begin
            @(negedge clk); c++;
        end while (idxA !== 6'd17 && c < 60);
        total++;
        if (idxA !== 6'd17) begin
            bad++; $display("FAIL rstmid_reach: got idx %0d, want 17", idxA);
        end
        rst_n = 1'b0; #1;
        total++;
        if ({rkA, idxA, validA, busyA, doneA} !== '0) begin
            bad++; $display("FAIL rstmid_clear: got key=%h idx=%0d v=%b b=%b d=%b, want all 0", rkA, idxA, validA, busyA, doneA);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (doneA !== 1'b0 || busyA !== 1'b0) begin
            bad++; $display("FAIL rstmid_nodone: got d=%b b=%b, want 0 0", doneA, busyA);
        end
        loadA80(80'hA5A5_5A5A_C3C3_3C3C_9696, 1'b0);
        collect80(1'b0, -1);
        check_fwd_A("rstmid");
        check_done_A("rstmid");
    endtask

`ifdef PRESENT_KEY_INVERSE_EN
    task automatic test_inverse;
        model80(80'h0123_4567_89AB_CDEF_FEDC);
        loadA80(fin80, 1'b1);
        collect80(1'b1, -1);
        total++;
        if (capN !== 32 || holdErr !== 0) begin
            bad++; $display("FAIL inv_count: got %0d keys %0d hold errs, want 32 0", capN, holdErr);
        end
        for (int j = 0; j < capN; j++) begin
            total++;
            if (capKey[j] !== exp80[32 - j] || capIdx[j] !== 6'(32 - j)) begin
                bad++; $display("FAIL inv_k%0d: got %h idx %0d, want %h", 32 - j, capKey[j], capIdx[j], exp80[32 - j]);
            end
        end
        total++;
        if (capKey[31] !== 64'h0123_4567_89AB_CDEF) begin
            bad++; $display("FAIL inv_master: got %h, want 0123456789abcdef", capKey[31]);
        end
        check_done_A("inv");
    endtask
`else
    task automatic test_inverse_ignored;
        model80(80'h0123_4567_89AB_CDEF_FEDC);
        loadA80(80'h0123_4567_89AB_CDEF_FEDC, 1'b1);
        collect80(1'b0, -1);
        check_fwd_A("invoff");
        check_done_A("invoff");
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        keyInA = '0; loadA = 1'b0; invA = 1'b0; rdyA = 1'b0;
        keyInB = '0; loadB = 1'b0; invB = 1'b0; rdyB = 1'b0;
        test_reset;
        test_fwd80;
        test_fwd128;
        test_ready_toggle;
        test_load_during_run;
        test_reset_mid;
`ifdef PRESENT_KEY_INVERSE_EN
        test_inverse;
`else
        test_inverse_ignored;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
